// File: rtl/key_event_ctrl.sv
// key_event_ctrl: qualifies raw keypad scanner output into press/release
// events, maps each to a linear key index and queues them in a small FIFO
// that the game logic drains with a valid/ready handshake.
module key_event_ctrl #(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned RELEASE_CYC = 16,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned FIFO_AW     = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4:0]         key_code,
   input  logic               key_ready,
   input  logic               enable,
   output logic               evt_valid,
   output logic [4:0]         evt_idx,
   output logic               evt_press,
   input  logic               evt_ready,
   output logic [FIFO_AW:0]   fifo_cnt,
   output logic               overflow
);

   localparam int unsigned DEPTH  = 2 ** FIFO_AW;
   localparam int unsigned FCNT_W = FIFO_AW + 1;
   localparam int unsigned EVT_W  = 6;

   localparam logic [CNT_W-1:0]  SETTLE_C  = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0]  RELEASE_C = CNT_W'(RELEASE_CYC);
   localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(DEPTH);
   localparam bit                SETTLE_NOW = (SETTLE_CYC <= 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PQUAL = 2'd1,
      S_HELD  = 2'd2
   } state_t;

   // qualifier state
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [4:0]         r_code;
   logic               r_push;
   logic               r_push_press;
   logic [4:0]         r_push_idx;

   // FIFO state
   logic [EVT_W-1:0]   r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr;
   logic [FIFO_AW-1:0] r_rd;
   logic [FCNT_W-1:0]  r_fcnt;
   logic               r_valid;
   logic [4:0]         r_head_idx;
   logic               r_head_press;
   logic               r_ovf;

   logic               w_key;
   logic               w_same;
   logic [4:0]         w_new_idx;
   logic [4:0]         w_cur_idx;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_pop;
   logic               w_full;
   logic               w_push_acc;
   logic               w_drop;
   logic [FCNT_W-1:0]  w_cnt_after_pop;
   logic [FCNT_W-1:0]  w_fcnt_nxt;
   logic [FIFO_AW-1:0] w_rd_nxt;
   logic [EVT_W-1:0]   w_push_data;

   // An out-of-range row counts as no key at all.
   assign w_key     = key_ready & (key_code[4:2] <= 3'd4);
   assign w_same    = (key_code == r_code);
   assign w_new_idx = {key_code[4:2], 2'b00} + {3'b000, key_code[1:0]};
   assign w_cur_idx = {r_code[4:2], 2'b00} + {3'b000, r_code[1:0]};
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Press/release qualifier; an event is handed to the FIFO one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_code       <= '0;
         r_push       <= 1'b0;
         r_push_press <= 1'b0;
         r_push_idx   <= '0;
      end else begin
         r_push <= 1'b0;
         if (!enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  if (w_key) begin
                     r_code <= key_code;
                     if (SETTLE_NOW) begin
                        r_push       <= 1'b1;
                        r_push_press <= 1'b1;
                        r_push_idx   <= w_new_idx;
                        r_state      <= S_HELD;
                     end else begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_PQUAL;
                     end
                  end
               end
               S_PQUAL: begin
                  if (!w_key) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                  end else if (!w_same) begin
                     r_code <= key_code;
                     r_cnt  <= CNT_W'(1);
                  end else if (w_cnt_inc >= SETTLE_C) begin
                     r_push       <= 1'b1;
                     r_push_press <= 1'b1;
                     r_push_idx   <= w_cur_idx;
                     r_cnt        <= '0;
                     r_state      <= S_HELD;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               S_HELD: begin
                  if (w_key && w_same) begin
                     r_cnt <= '0;
                  end else if (w_key) begin
                     // rollover: release the old key, start qualifying the new one
                     r_push       <= 1'b1;
                     r_push_press <= 1'b0;
                     r_push_idx   <= w_cur_idx;
                     r_code       <= key_code;
                     r_cnt        <= CNT_W'(1);
                     r_state      <= S_PQUAL;
                  end else if (w_cnt_inc >= RELEASE_C) begin
                     r_push       <= 1'b1;
                     r_push_press <= 1'b0;
                     r_push_idx   <= w_cur_idx;
                     r_cnt        <= '0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   // A pop in the same cycle frees the slot for a push into a full FIFO.
   assign w_pop           = evt_ready & (r_fcnt != '0);
   assign w_full          = (r_fcnt == DEPTH_C);
   assign w_push_acc      = r_push & (~w_full | w_pop);
   assign w_drop          = r_push & w_full & ~w_pop;
   assign w_cnt_after_pop = r_fcnt - FCNT_W'(w_pop);
   assign w_fcnt_nxt      = w_cnt_after_pop + FCNT_W'(w_push_acc);
   assign w_rd_nxt        = r_rd + FIFO_AW'(w_pop);
   assign w_push_data     = {r_push_press, r_push_idx};

   // Event storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_mem[r_wr] <= w_push_data;
      end
   end

   // FIFO pointers, occupancy, sticky overflow and registered show-ahead head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr         <= '0;
         r_rd         <= '0;
         r_fcnt       <= '0;
         r_valid      <= 1'b0;
         r_head_idx   <= '0;
         r_head_press <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr <= r_wr + FIFO_AW'(1);
         end
         r_rd    <= w_rd_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_valid <= (w_fcnt_nxt != '0);
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_push_acc && (w_cnt_after_pop == '0)) begin
            r_head_press <= r_push_press;
            r_head_idx   <= r_push_idx;
         end else if (w_fcnt_nxt != '0) begin
            r_head_press <= r_mem[w_rd_nxt][5];
            r_head_idx   <= r_mem[w_rd_nxt][4:0];
         end
      end
   end

   assign evt_valid = r_valid;
   assign evt_idx   = r_head_idx;
   assign evt_press = r_head_press;
   assign fifo_cnt  = r_fcnt;
   assign overflow  = r_ovf;

endmodule
